core_ctrl: RTL and testbench

Hardware instruction sequencer that generates the 34-bit core instruction word and the D_xmem data word. It replaces hand-driven bench stimulus for the 2D systolic accelerator core. One start pulse runs a full conv pass:
- Stream activations into xmem.
- For each of len_kij kernel offsets: stream weights into xmem, move them through L0 into the PEs, replay the activations, and drain the OFIFO into pmem, accumulating from kij=1 onward.

The block sits between the host/DMA stream and core.inst / core.D_xmem. All dimensions are parametrised.

---
 rtl/core_ctrl_pkg.sv | 40 ++++
 rtl/core_ctrl_pack.sv | 62 ++++++
 rtl/core_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_core_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Purpose: shared types and constants for the core instruction sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_ctrl_pkg;

  // Instruction word layout, bit positions
  localparam int INST_W      = 34;
  localparam int INST_ABW    = 11;
  localparam int ACC_B       = 33;
  localparam int CEN_P_B     = 32;
  localparam int WEN_P_B     = 31;
  localparam int A_P_MSB     = 30;
  localparam int A_P_LSB     = 20;
  localparam int CEN_X_B     = 19;
  localparam int WEN_X_B     = 18;
  localparam int A_X_MSB     = 17;
  localparam int A_X_LSB     = 7;
  localparam int OFIFO_RD_B  = 6;
  localparam int IFIFO_WR_B  = 5;
  localparam int IFIFO_RD_B  = 4;
  localparam int L0_RD_B     = 3;
  localparam int L0_WR_B     = 2;
  localparam int EXECUTE_B   = 1;
  localparam int LOAD_B      = 0;

  // Only the active-low memory enables are set: nothing happens in the core
  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    IDLE, XWR, WWR, WL0, WLOAD, XL0, EXEC, DRAIN, DONE
  } state_t;

  // Counter width covering max(a, b) + 1 inclusive
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = ((a > b) ? a : b) + 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/core_ctrl_pack.sv
// Purpose: registers decoded control fields and xmem data into the 34-bit inst word.
// Latency: 1 cycle from decoded fields to inst/D_xmem.
// Backpressure: none; a new word is captured every cycle.
module core_ctrl_pack
  import core_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                acc,
  input  logic                cen_p,
  input  logic                wen_p,
  input  logic [INST_ABW-1:0] a_p,
  input  logic                cen_x,
  input  logic                wen_x,
  input  logic [INST_ABW-1:0] a_x,
  input  logic                ofifo_rd,
  input  logic                ififo_wr,
  input  logic                ififo_rd,
  input  logic                l0_rd,
  input  logic                l0_wr,
  input  logic                execute,
  input  logic                load,
  input  logic [DW-1:0]       d_in,
  output logic [INST_W-1:0]   inst,
  output logic [DW-1:0]       D_xmem
);

  logic [INST_W-1:0] nxt_inst;

  // Place each field at its bit position in the instruction word
  always_comb begin
    nxt_inst                   = IDLE_INST;
    nxt_inst[ACC_B]            = acc;
    nxt_inst[CEN_P_B]          = cen_p;
    nxt_inst[WEN_P_B]          = wen_p;
    nxt_inst[A_P_MSB:A_P_LSB]  = a_p;
    nxt_inst[CEN_X_B]          = cen_x;
    nxt_inst[WEN_X_B]          = wen_x;
    nxt_inst[A_X_MSB:A_X_LSB]  = a_x;
    nxt_inst[OFIFO_RD_B]       = ofifo_rd;
    nxt_inst[IFIFO_WR_B]       = ififo_wr;
    nxt_inst[IFIFO_RD_B]       = ififo_rd;
    nxt_inst[L0_RD_B]          = l0_rd;
    nxt_inst[L0_WR_B]          = l0_wr;
    nxt_inst[EXECUTE_B]        = execute;
    nxt_inst[LOAD_B]           = load;
  end

  // Output register; reset parks the core on the idle word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst   <= IDLE_INST;
      D_xmem <= '0;
    end else begin
      inst   <= nxt_inst;
      D_xmem <= d_in;
    end
  end

endmodule

// File: rtl/core_ctrl.sv
// Purpose: sequences one full conv pass (xmem fill, per-kij weight load/exec/drain) as core inst words.
// Latency: inst/D_xmem for a state cycle appear one cycle later; busy rises the cycle after start.
// Backpressure: stalls on in_valid=0 during xmem writes and on ofifo_valid=0 during drain.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int bw      = 4,
  parameter int len_kij = 9,
  parameter int len_nij = 36,
  parameter int addr_bw = 11,
  parameter int w_base  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic [bw*row-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                ofifo_valid,
  output logic [INST_W-1:0]   inst,
  output logic [bw*row-1:0]   D_xmem,
  output logic [3:0]          kij_idx
);

  localparam int CW = cnt_width(len_nij, col + row);
  localparam logic [CW-1:0]      NIJ       = CW'(len_nij);
  localparam logic [CW-1:0]      NIJ_LAST  = CW'(len_nij - 1);
  localparam logic [CW-1:0]      COL       = CW'(col);
  localparam logic [CW-1:0]      COL_LAST  = CW'(col - 1);
  localparam logic [CW-1:0]      LOAD_LAST = CW'(col + row - 1);
  localparam logic [3:0]         KIJ_LAST  = 4'(len_kij - 1);
  localparam logic [addr_bw-1:0] W_BASE    = addr_bw'(w_base);

  if (len_nij > w_base || w_base + col > 2**addr_bw) begin : g_bad_map
    $error("core_ctrl: activation and weight regions overlap or exceed xmem");
  end
  if (addr_bw != INST_ABW) begin : g_bad_abw
    $error("core_ctrl: addr_bw must match the inst address fields");
  end
  if (len_kij < 1 || len_kij > 16 || len_nij < 1 || len_nij > 512) begin : g_bad_len
    $error("core_ctrl: len_kij or len_nij out of range");
  end

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              xfer;
  logic [addr_bw-1:0] cnt_a;

  logic              d_acc, d_cen_p, d_wen_p, d_cen_x, d_wen_x;
  logic              d_ofifo_rd, d_l0_rd, d_l0_wr, d_execute, d_load;
  logic [addr_bw-1:0] d_a_p, d_a_x;
  logic [bw*row-1:0] d_data;

  assign xfer  = in_valid & in_ready;
  assign cnt_a = addr_bw'(cnt);

  // Decode the control fields for the current state cycle
  always_comb begin
    d_acc      = 1'b0;
    d_cen_p    = 1'b1;
    d_wen_p    = 1'b1;
    d_a_p      = '0;
    d_cen_x    = 1'b1;
    d_wen_x    = 1'b1;
    d_a_x      = '0;
    d_ofifo_rd = 1'b0;
    d_l0_rd    = 1'b0;
    d_l0_wr    = 1'b0;
    d_execute  = 1'b0;
    d_load     = 1'b0;
    d_data     = '0;
    case (state)
      XWR: if (xfer) begin
        d_cen_x = 1'b0;
        d_wen_x = 1'b0;
        d_a_x   = cnt_a;
        d_data  = in_data;
      end
      WWR: if (xfer) begin
        d_cen_x = 1'b0;
        d_wen_x = 1'b0;
        d_a_x   = W_BASE + cnt_a;
        d_data  = in_data;
      end
      WL0: begin
        if (cnt < COL) begin
          d_cen_x = 1'b0;
          d_a_x   = W_BASE + cnt_a;
        end
        // xmem read data lands one cycle later, so L0 write trails the read
        d_l0_wr = (cnt != '0);
      end
      WLOAD: begin
        d_load  = 1'b1;
        d_l0_rd = (cnt < COL);
      end
      XL0: begin
        if (cnt < NIJ) begin
          d_cen_x = 1'b0;
          d_a_x   = cnt_a;
        end
        d_l0_wr = (cnt != '0);
      end
      EXEC: begin
        d_l0_rd   = 1'b1;
        d_execute = 1'b1;
      end
      DRAIN: if (ofifo_valid && cnt < NIJ) begin
        d_ofifo_rd = 1'b1;
        d_cen_p    = 1'b0;
        d_wen_p    = 1'b0;
        d_a_p      = cnt_a;
        d_acc      = (kij_idx != '0);
      end
      default: ;
    endcase
  end

  // Pass sequencer with registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      kij_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= XWR;
          cnt      <= '0;
          kij_idx  <= '0;
          busy     <= 1'b1;
          in_ready <= 1'b1;
        end
        XWR: if (xfer) begin
          if (cnt == NIJ_LAST) begin
            state <= WWR;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        end
        WWR: if (xfer) begin
          if (cnt == COL_LAST) begin
            state    <= WL0;
            cnt      <= '0;
            in_ready <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        WL0: if (cnt == COL) begin
          state <= WLOAD;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        WLOAD: if (cnt == LOAD_LAST) begin
          state <= XL0;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        XL0: if (cnt == NIJ) begin
          state <= EXEC;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        EXEC: if (cnt == NIJ_LAST) begin
          state <= DRAIN;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        DRAIN: if (ofifo_valid) begin
          if (cnt == NIJ_LAST) begin
            cnt <= '0;
            if (kij_idx == KIJ_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              kij_idx  <= kij_idx + 4'd1;
              state    <= WWR;
              in_ready <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  core_ctrl_pack #(.DW(bw*row)) u_pack (
    .clk      (clk),
    .reset    (reset),
    .acc      (d_acc),
    .cen_p    (d_cen_p),
    .wen_p    (d_wen_p),
    .a_p      (d_a_p),
    .cen_x    (d_cen_x),
    .wen_x    (d_wen_x),
    .a_x      (d_a_x),
    .ofifo_rd (d_ofifo_rd),
    .ififo_wr (1'b0),
    .ififo_rd (1'b0),
    .l0_rd    (d_l0_rd),
    .l0_wr    (d_l0_wr),
    .execute  (d_execute),
    .load     (d_load),
    .d_in     (d_data),
    .inst     (inst),
    .D_xmem   (D_xmem)
  );

endmodule

// File: tb/tb_core_ctrl.sv
// Purpose: directed checks of core_ctrl pass sequencing, stalls, reset abort and a small config.
// Latency: n/a.
// Backpressure: n/a.
module tb_core_ctrl;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        reset, start, in_valid, ofifo_valid;
  logic [31:0] in_data;
  logic        busy, done, in_ready;
  logic [33:0] inst;
  logic [31:0] D_xmem;
  logic [3:0]  kij_idx;

  // small instance: len_kij=1, len_nij=4, col=row=4
  logic        s_reset, s_start, s_in_valid, s_ofifo_valid;
  logic [15:0] s_in_data;
  logic        s_busy, s_done, s_in_ready;
  logic [33:0] s_inst;
  logic [15:0] s_D_xmem;
  logic [3:0]  s_kij_idx;

  core_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ofifo_valid(ofifo_valid), .inst(inst), .D_xmem(D_xmem), .kij_idx(kij_idx)
  );

  core_ctrl #(.row(4), .col(4), .bw(4), .len_kij(1), .len_nij(4), .addr_bw(11), .w_base(1024)) u_small (
    .clk(clk), .reset(s_reset), .start(s_start), .busy(s_busy), .done(s_done),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .ofifo_valid(s_ofifo_valid), .inst(s_inst), .D_xmem(s_D_xmem), .kij_idx(s_kij_idx)
  );

  int total = 0;
  int bad   = 0;

  logic [33:0] inst_q[$];
  logic        busy_q[$];
  logic        done_q[$];
  logic [31:0] dx_q[$];
  logic        ov_q[$];
  logic [3:0]  kij_q[$];
  bit          saw_done;

  // Drives one pass cycle by cycle and logs outputs at each falling edge.
  // Cycle 0 carries the start pulse, so the first XWR cycle is cycle 1.
  task automatic run_pass(input bit alt_valid, input bit drop_en, input bit extra_start,
                          input int abort_at, input int budget);
    int  tail, idx, drop_left, pw;
    bit  xfer, dropped;
    inst_q.delete(); busy_q.delete(); done_q.delete();
    dx_q.delete(); ov_q.delete(); kij_q.delete();
    saw_done = 0; tail = 0; idx = 0; drop_left = 0; pw = 0; dropped = 0;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; ofifo_valid = 1'b1; in_data = 32'hD000_0000;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      inst_q.push_back(inst); busy_q.push_back(busy); done_q.push_back(done);
      dx_q.push_back(D_xmem); ov_q.push_back(ofifo_valid); kij_q.push_back(kij_idx);
      xfer = in_valid && in_ready;
      if (!inst[32] && !inst[31]) pw++;
      if (drop_en && !dropped && pw >= 118) begin dropped = 1; drop_left = 5; end
      if (done) saw_done = 1;
      if (saw_done) tail++;
      if (tail > 20 || c == abort_at) break;
      @(posedge clk); #1;
      start = extra_start && (c + 1 == 100 || c + 1 == 1315);
      reset = !(c + 1 == abort_at);
      if (xfer) begin idx++; in_data = 32'hD000_0000 | 32'(idx); end
      if (alt_valid && c + 1 <= 71) in_valid = (c % 2 == 0);
      else in_valid = 1'b1;
      ofifo_valid = (drop_left == 0);
      if (drop_left > 0) drop_left--;
    end
    start = 1'b0;
    if (abort_at >= 0) begin @(posedge clk); #1; reset = 1'b1; end
  endtask

  function automatic int busy_count();
    int n = 0;
    foreach (busy_q[i]) if (busy_q[i]) n++;
    return n;
  endfunction

  function automatic int done_count();
    int n = 0;
    foreach (done_q[i]) if (done_q[i]) n++;
    return n;
  endfunction

  function automatic int count_bit(input int pos);
    int n = 0;
    logic [33:0] w;
    foreach (inst_q[i]) begin w = inst_q[i]; if (w[pos]) n++; end
    return n;
  endfunction

  // xmem writes: 0..35 once, then 1024..1031 per kij; data tags the transfer number
  function automatic int xmem_write_errs();
    int j = 0, e = 0, ea;
    logic [33:0] w;
    foreach (inst_q[i]) begin
      w = inst_q[i];
      if (!w[19] && !w[18]) begin
        ea = (j < 36) ? j : 1024 + (j - 36) % 8;
        if (int'(w[17:7]) != ea || dx_q[i] !== (32'hD000_0000 | 32'(j))) e++;
        j++;
      end
    end
    if (j != 36 + 8 * 9) e += 1000;
    return e;
  endfunction

  // xmem reads per kij: weights 1024..1031 then activations 0..35
  function automatic int xmem_read_errs();
    int j = 0, e = 0, k, ea;
    logic [33:0] w;
    foreach (inst_q[i]) begin
      w = inst_q[i];
      if (!w[19] && w[18]) begin
        k  = j % 44;
        ea = (k < 8) ? 1024 + k : k - 8;
        if (int'(w[17:7]) != ea) e++;
        j++;
      end
    end
    if (j != 44 * 9) e += 1000;
    return e;
  endfunction

  // pmem writes: 0..35 per kij, acc only from kij=1
  function automatic int pmem_errs();
    int j = 0, e = 0;
    logic [33:0] w;
    foreach (inst_q[i]) begin
      w = inst_q[i];
      if (!w[32] && !w[31]) begin
        if (int'(w[30:20]) != j % 36 || w[33] !== (j >= 36)) e++;
        if (!w[6]) e++;
        j++;
      end
    end
    if (j != 36 * 9) e += 1000;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b0; s_reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (inst !== IDLE_W) begin bad++; $display("FAIL rst_inst: got %h want %h", inst, IDLE_W); end
    total++; if (D_xmem !== 32'h0) begin bad++; $display("FAIL rst_dxmem: got %h want 0", D_xmem); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (kij_idx !== 4'd0) begin bad++; $display("FAIL rst_kij: got %0d want 0", kij_idx); end
    total++; if (s_inst !== IDLE_W) begin bad++; $display("FAIL rst_small_inst: got %h want %h", s_inst, IDLE_W); end
    @(posedge clk); #1;
    reset = 1'b1; s_reset = 1'b1;
    in_valid = 1'b1; ofifo_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (inst !== IDLE_W || in_ready !== 1'b0) begin
      bad++; $display("FAIL idle_inputs: got inst=%h rdy=%b want inst=%h rdy=0", inst, in_ready, IDLE_W);
    end
  endtask

  task automatic test_full_pass();
    run_pass(0, 0, 0, -1, 3000);
    total++; if (!saw_done) begin bad++; $display("FAIL full_timeout: got no done want done"); end
    total++; if (busy_count() != 1314) begin bad++; $display("FAIL full_busy: got %0d want 1314", busy_count()); end
    total++; if (done_count() != 1) begin bad++; $display("FAIL full_done_cnt: got %0d want 1", done_count()); end
    total++; if (busy_q[1] !== 1'b1 || busy_q[1314] !== 1'b1 || done_q[1315] !== 1'b1) begin
      bad++; $display("FAIL full_window: got b1=%b b1314=%b d1315=%b want 1 1 1", busy_q[1], busy_q[1314], done_q[1315]);
    end
    total++; if (xmem_write_errs() != 0) begin bad++; $display("FAIL full_xmem_wr: got %0d errors want 0", xmem_write_errs()); end
    total++; if (xmem_read_errs() != 0) begin bad++; $display("FAIL full_xmem_rd: got %0d errors want 0", xmem_read_errs()); end
    total++; if (pmem_errs() != 0) begin bad++; $display("FAIL full_pmem: got %0d errors want 0", pmem_errs()); end
    total++; if (count_bit(0) != 144) begin bad++; $display("FAIL full_load: got %0d want 144", count_bit(0)); end
    total++; if (count_bit(1) != 324) begin bad++; $display("FAIL full_exec: got %0d want 324", count_bit(1)); end
    total++; if (count_bit(2) != 396) begin bad++; $display("FAIL full_l0_wr: got %0d want 396", count_bit(2)); end
    total++; if (count_bit(3) != 396) begin bad++; $display("FAIL full_l0_rd: got %0d want 396", count_bit(3)); end
    total++; if (count_bit(6) != 324) begin bad++; $display("FAIL full_ofifo_rd: got %0d want 324", count_bit(6)); end
  endtask

  task automatic test_xwr_stall();
    int e = 0;
    logic [33:0] w;
    run_pass(1, 0, 0, -1, 3000);
    for (int r = 0; r <= 70; r++) begin
      w = inst_q[r + 2];
      if (r % 2 == 1) begin
        if (w !== IDLE_W) e++;
      end else if (w[19] || w[18] || int'(w[17:7]) != r / 2) e++;
    end
    total++; if (e != 0) begin bad++; $display("FAIL xwr_gaps: got %0d errors want 0", e); end
    w = inst_q[73];
    total++; if (w[19] || w[18] || w[17:7] !== 11'd1024) begin
      bad++; $display("FAIL xwr_len: got inst %h want first weight write at 1024", w);
    end
    total++; if (busy_count() != 1349) begin bad++; $display("FAIL xwr_busy: got %0d want 1349", busy_count()); end
    total++; if (xmem_write_errs() != 0) begin bad++; $display("FAIL xwr_xmem_wr: got %0d errors want 0", xmem_write_errs()); end
  endtask

  task automatic test_drain_stall();
    int n = 0, e = 0;
    logic [33:0] w;
    run_pass(0, 1, 0, -1, 3000);
    for (int k = 0; k + 1 < ov_q.size(); k++) begin
      if (!ov_q[k]) begin
        n++;
        w = inst_q[k + 1];
        if (w[6] || !w[32] || kij_q[k] !== 4'd3) e++;
      end
    end
    total++; if (n != 5 || e != 0) begin bad++; $display("FAIL drain_gap: got %0d drops %0d errors want 5 drops 0 errors", n, e); end
    total++; if (busy_count() != 1319) begin bad++; $display("FAIL drain_busy: got %0d want 1319", busy_count()); end
    total++; if (pmem_errs() != 0) begin bad++; $display("FAIL drain_pmem: got %0d errors want 0", pmem_errs()); end
  endtask

  task automatic test_abort_restart();
    logic [33:0] w;
    run_pass(0, 0, 0, 690, 3000);
    w = inst_q[689];
    total++; if (kij_q[689] !== 4'd4 || !w[1]) begin
      bad++; $display("FAIL abort_pre: got kij=%0d exec=%b want kij=4 exec=1", kij_q[689], w[1]);
    end
    total++; if (inst_q[690] !== IDLE_W || busy_q[690] !== 1'b0 || kij_q[690] !== 4'd0) begin
      bad++; $display("FAIL abort_rst: got inst=%h busy=%b kij=%0d want %h 0 0", inst_q[690], busy_q[690], kij_q[690], IDLE_W);
    end
    run_pass(0, 0, 0, -1, 3000);
    total++; if (busy_count() != 1314 || done_count() != 1) begin
      bad++; $display("FAIL restart_busy: got busy=%0d done=%0d want 1314 1", busy_count(), done_count());
    end
    total++; if (xmem_write_errs() != 0 || kij_q[2] !== 4'd0) begin
      bad++; $display("FAIL restart_seq: got %0d errors kij=%0d want 0 0", xmem_write_errs(), kij_q[2]);
    end
  endtask

  task automatic test_start_ignored();
    run_pass(0, 0, 1, -1, 3000);
    total++; if (busy_count() != 1314) begin bad++; $display("FAIL start_busy: got %0d want 1314", busy_count()); end
    total++; if (done_count() != 1 || busy_q[busy_q.size() - 1] !== 1'b0) begin
      bad++; $display("FAIL start_second: got done=%0d busy_end=%b want 1 0", done_count(), busy_q[busy_q.size() - 1]);
    end
  endtask

  task automatic test_small();
    int nb = 0, nd = 0, na = 0, np = 0, nx = 0, pe = 0;
    s_in_valid = 1'b1; s_ofifo_valid = 1'b1; s_in_data = 16'h1234;
    @(posedge clk); #1; s_start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (s_busy) nb++;
      if (s_done) nd++;
      if (s_inst[33]) na++;
      if (!s_inst[32] && !s_inst[31]) begin
        if (int'(s_inst[30:20]) != np) pe++;
        np++;
      end
      if (!s_inst[19] && !s_inst[18]) nx++;
      @(posedge clk); #1; s_start = 1'b0;
    end
    total++; if (nb != 34) begin bad++; $display("FAIL small_busy: got %0d want 34", nb); end
    total++; if (nd != 1) begin bad++; $display("FAIL small_done: got %0d want 1", nd); end
    total++; if (na != 0) begin bad++; $display("FAIL small_acc: got %0d want 0", na); end
    total++; if (np != 4 || pe != 0) begin bad++; $display("FAIL small_pmem: got %0d writes %0d errors want 4 0", np, pe); end
    total++; if (nx != 8) begin bad++; $display("FAIL small_xmem: got %0d want 8", nx); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; ofifo_valid = 1'b0; in_data = '0;
    s_reset = 1'b0; s_start = 1'b0; s_in_valid = 1'b0; s_ofifo_valid = 1'b0; s_in_data = '0;
    test_reset();
    test_full_pass();
    test_xwr_stall();
    test_drain_stall();
    test_abort_restart();
    test_start_ignored();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
